// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with registered output stage feeding a UART transmitter over valid/ready
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_data_valid,
    input  logic          tx_data_ready
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH-1];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_ok, xfer, arr_ne, load, pop, push, bypass;

    // Pointers step through DEPTH-1 slots and wrap back to zero after the last one
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 2)) ? '0 : p + PW'(1);
    endfunction

    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;

    // Handshake decode; the array holds level minus the byte sitting in the output register
    always_comb begin
        xfer   = tx_data_valid && tx_data_ready;
        wr_ok  = wr_en && !full && !clr;
        arr_ne = level > LW'(tx_data_valid);
        load   = !tx_data_valid || xfer;
        pop    = load && arr_ne;
        bypass = xfer && !arr_ne && wr_ok;
        push   = wr_ok && !bypass;
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Level, pointers, sticky overflow and the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level         <= '0;
            overflow      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tx_data_valid <= 1'b0;
            tx_data       <= 8'h00;
        end else if (clr) begin
            level         <= '0;
            overflow      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tx_data_valid <= 1'b0;
        end else begin
            level <= level + LW'(wr_ok) - LW'(xfer);
            if (wr_en && full) overflow <= 1'b1;
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            if (load) begin
                tx_data_valid <= arr_ne || bypass;
                tx_data       <= arr_ne ? mem[rd_ptr] : bypass ? wr_data : tx_data;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized scoreboard bench for uart_tx_fifo
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n, clr, wr_en, tx_data_ready;
    logic [7:0]    wr_data;
    logic          full, empty, overflow, tx_data_valid;
    logic [LW-1:0] level;
    logic [7:0]    tx_data;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;

    logic [7:0] q[$];
    int         m_level;
    logic       m_ovf, m_valid, prev_hold;
    logic [7:0] prev_data;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            wr_data = base + 8'(i);
            wr_en = 1'b1;
            tick;
        end
        wr_en = 1'b0;
    endtask

    task automatic drain;
        tx_data_ready = 1'b1;
        for (int i = 0; i < 100 && !empty; i++) tick;
        tx_data_ready = 1'b0;
        chk("drain_empty", 32'(empty), 1);
    endtask

    // Monitor: compare DUT against the queue model, then predict the effect of the coming edge
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_level = 0;
            m_ovf = 1'b0;
            m_valid = 1'b0;
            prev_hold = 1'b0;
        end else begin
            logic x, acc, nv;
            int old_sz;
            chk("mon_level", 32'(level), 32'(m_level));
            chk("mon_full", 32'(full), 32'(m_level == DEPTH));
            chk("mon_empty", 32'(empty), 32'(m_level == 0));
            chk("mon_overflow", 32'(overflow), 32'(m_ovf));
            chk("mon_valid", 32'(tx_data_valid), 32'(m_valid));
            if (tx_data_valid && q.size() > 0) chk("mon_tx_data", 32'(tx_data), 32'(q[0]));
            if (prev_hold) begin
                chk("hold_valid", 32'(tx_data_valid), 1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
            x = tx_data_valid && tx_data_ready;
            if (x) n_xfer++;
            prev_hold = tx_data_valid && !tx_data_ready && !clr;
            prev_data = tx_data;
            if (clr) begin
                q.delete();
                m_level = 0;
                m_ovf = 1'b0;
                m_valid = 1'b0;
            end else begin
                old_sz = q.size();
                acc = wr_en && m_level < DEPTH;
                if (wr_en && !acc) m_ovf = 1'b1;
                if (x && q.size() > 0) void'(q.pop_front());
                if (acc) q.push_back(wr_data);
                m_level = q.size();
                nv = (m_valid && !x) ? 1'b1 : m_valid ? (q.size() > 0) : (old_sz > 0);
                m_valid = nv;
            end
        end
    end

    initial begin
        int sent, n0;
        logic acc;
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_valid", 32'(tx_data_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);

        wr_data = 8'hA5; wr_en = 1'b1;
        tick;
        wr_en = 1'b0;
        chk("lat_level_E", 32'(level), 1);
        chk("lat_valid_E", 32'(tx_data_valid), 0);
        tick;
        chk("lat_valid_E1", 32'(tx_data_valid), 1);
        chk("lat_data_E1", 32'(tx_data), 32'hA5);
        repeat (50) tick;
        chk("stall_valid", 32'(tx_data_valid), 1);
        chk("stall_data", 32'(tx_data), 32'hA5);
        tx_data_ready = 1'b1;
        tick;
        tx_data_ready = 1'b0;
        chk("lat_pop_valid", 32'(tx_data_valid), 0);
        chk("lat_pop_level", 32'(level), 0);

        fill(DEPTH, 8'h00);
        chk("fill_full", 32'(full), 1);
        chk("fill_level", 32'(level), DEPTH);
        wr_data = 8'hFF; wr_en = 1'b1;
        tick;
        wr_en = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), DEPTH);
        drain;

        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        fill(DEPTH, 8'h80);
        wr_data = 8'hEE; wr_en = 1'b1; tx_data_ready = 1'b1;
        tick;
        wr_en = 1'b0; tx_data_ready = 1'b0;
        chk("fullsim_level", 32'(level), DEPTH - 1);
        chk("fullsim_ovf", 32'(overflow), 1);
        drain;

        fill(1, 8'h11);
        tick;
        chk("l1_valid_pre", 32'(tx_data_valid), 1);
        wr_data = 8'h55; wr_en = 1'b1; tx_data_ready = 1'b1;
        tick;
        wr_en = 1'b0; tx_data_ready = 1'b0;
        chk("l1_level", 32'(level), 1);
        chk("l1_valid", 32'(tx_data_valid), 1);
        chk("l1_data", 32'(tx_data), 32'h55);
        drain;

        fill(7, 8'h30);
        chk("clr_pre_level", 32'(level), 7);
        clr = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick;
        clr = 1'b0; wr_en = 1'b0;
        chk("clr_level", 32'(level), 0);
        chk("clr_valid", 32'(tx_data_valid), 0);
        chk("clr_overflow", 32'(overflow), 0);
        tick;
        chk("clr_wr_ignored", 32'(level), 0);

        fill(10, 8'h40);
        tx_data_ready = 1'b1;
        repeat (3) tick;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_valid", 32'(tx_data_valid), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        chk("arst_tx_data", 32'(tx_data), 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tx_data_ready = 1'b0;

        sent = 0;
        n0 = n_xfer;
        for (int c = 0; c < 3000 && sent < 3 * DEPTH + 5; c++) begin
            wr_data = sent[7:0];
            wr_en = 1'($urandom_range(0, 1));
            tx_data_ready = 1'($urandom_range(0, 1));
            acc = wr_en && !full;
            tick;
            if (acc) sent++;
        end
        wr_en = 1'b0;
        chk("stream_sent", 32'(sent), 3 * DEPTH + 5);
        drain;
        chk("stream_received", 32'(n_xfer - n0), 3 * DEPTH + 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO directly upstream of the UART transmitter.
- Buffers bytes written by the core or bus side.
- Drains them over the transmitter's valid/ready handshake (tx_data, tx_data_valid, tx_data_ready), so a producer can post bursts without waiting one frame per byte.
- Provides full/empty/level status and a sticky overflow flag.

Parameters:
- DEPTH, 16, total byte capacity including the output register; power of two, at least 2.
- LW (localparam, not overridable), $clog2(DEPTH)+1, width of level.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; asynchronous assert, active-low
- clr  in  1  synchronous flush, active-high
- wr_data  in  8  byte to enqueue
- wr_en  in  1  enqueue request, sampled on rising edge
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- level  out  LW  bytes held, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- tx_data  out  8  byte presented to transmitter
- tx_data_valid  out  1  tx_data holds a valid byte
- tx_data_ready  in  1  transmitter ready

Behaviour:
- Reset (rst_n low, async): level=0, full=0, empty=1, overflow=0, tx_data_valid=0, tx_data=8'h00, pointers=0. The memory array is not reset.
- Storage:
  - DEPTH-1 entry circular array plus one output register driving tx_data/tx_data_valid, all registered.
  - Read/write pointers are log2(DEPTH-1 storage)+wrap bit, or an equivalent; wrap-around must be seamless.
- Accepted write: wr_en=1 and full=0 at the edge. wr_en while full: byte dropped, level unchanged, overflow<=1.
- Transfer: tx_data_valid=1 and tx_data_ready=1 at the edge. The byte is consumed at that edge.
- Output register rules:
  - Once tx_data_valid=1, tx_data and tx_data_valid stay stable until transfer. No retraction, no change of data.
  - The output register reloads from the array at the transfer edge if the array is non-empty. tx_data_valid then stays 1 (back-to-back).
  - Otherwise tx_data_valid falls to 0 at that edge.
  - An empty output register loads from the array on the next edge when the array holds data.
- Latency: a write accepted at edge E into a completely empty FIFO gives tx_data_valid=1 after edge E+1. No combinational path from wr_data to tx_data.
- Level:
  - +1 on an accepted write only, -1 on a transfer only, unchanged when both or neither occur.
  - full and empty are derived from the registered level and update on the same edge.
- Simultaneous write and transfer while full: the write is rejected (full is evaluated before the pop) and overflow is set. The transfer proceeds and level becomes DEPTH-1.
- Simultaneous write and transfer at level 1: the written byte becomes the next output. level stays 1. tx_data_valid stays 1.
- clr:
  - At the edge: level=0, pointers=0, tx_data_valid=0, overflow=0.
  - Has priority over a same-edge write, which is discarded and does not set overflow.
  - A transfer on the same edge is still considered complete, because the transmitter latched the byte.
- Reset mid-operation: the output register clears immediately (async), so tx_data_valid drops. A byte already latched by the transmitter still completes on the line.
- The transmitter's ready deasserts for one frame after acceptance. The FIFO must not depend on ready's timing beyond the valid&&ready rule.

Test Plan:
- Reset values → after rst_n release: empty=1, full=0, level=0, overflow=0, tx_data_valid=0.
- Latency test, ready held 0 → write 8'hA5 at edge E: level=1 after E, tx_data_valid=1 and tx_data=8'hA5 after E+1.
  - Hold ready=0 for 50 cycles: valid and data unchanged.
  - Assert ready for one cycle: valid=0, level=0.
- Fill test, DEPTH=16, ready=0 → write 0x00..0x0F: full=1, level=16.
  - Write 0xFF: overflow=1, level=16.
  - Then drain with ready=1: output sequence 0x00..0x0F in order, no 0xFF, empty=1 at end.
- Boundary simultaneous events:
  - Full FIFO, write plus transfer on the same edge: level=15, overflow=1.
  - Level 1, write 0x55 plus transfer: level=1, tx_data=0x55 next cycle.
- clr and reset mid-operation:
  - Level 7: assert clr together with wr_en → level=0, tx_data_valid=0, overflow=0; the write is ignored.
  - Then pulse rst_n low mid-drain: all outputs return to reset values asynchronously.
- Wrap and integration:
  - Stream 3×DEPTH+5 incrementing bytes with random wr_en and random ready → scoreboard sees exact order, no loss or duplication, level always equals writes minus transfers.
  - Connect the real transmitter (CLK_FRE=27, BAUD_RATE=115200): serial line decodes the same sequence.
